add_round_key: RTL and testbench

//  AES AddRoundKey stage: XORs the 4x4-byte cipher state from ShiftRows/MixColumns with the 4x4-byte round key.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/ark_byte_xor.sv | 12 +
 rtl/add_round_key.sv | 90 +++++++++
 tb/tb_add_round_key.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and helpers: byte/state typedefs and the column-major
// byte[r][c] <-> 128-bit vector mapping used throughout the round datapath.
package aes_pkg;

  localparam int unsigned AES_NB      = 4;
  localparam int unsigned AES_ROWS    = 4;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_STATE_W = AES_ROWS * AES_NB * AES_BYTE_W;

  typedef logic [AES_BYTE_W-1:0] byte_t;

  // Indexed as state[r][c].
  typedef byte_t [AES_ROWS-1:0][AES_NB-1:0] state_t;

  // Valid/data pair for one handshake register stage.
  typedef struct packed {
    logic                   valid;
    logic [AES_STATE_W-1:0] state;
    logic [AES_STATE_W-1:0] key;
  } ark_stage_t;

  // byte[r][c] lives at bits [8*(4*c+r) +: 8].
  function automatic state_t unpack_state(input logic [AES_STATE_W-1:0] v);
    state_t s;
    s = '0;
    for (int unsigned r = 0; r < AES_ROWS; r++) begin
      for (int unsigned c = 0; c < AES_NB; c++) begin
        s[r][c] = v[AES_BYTE_W*(AES_ROWS*c+r) +: AES_BYTE_W];
      end
    end
    return s;
  endfunction

  function automatic logic [AES_STATE_W-1:0] pack_state(input state_t s);
    logic [AES_STATE_W-1:0] v;
    v = '0;
    for (int unsigned r = 0; r < AES_ROWS; r++) begin
      for (int unsigned c = 0; c < AES_NB; c++) begin
        v[AES_BYTE_W*(AES_ROWS*c+r) +: AES_BYTE_W] = s[r][c];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/ark_byte_xor.sv
// One AddRoundKey byte lane: state byte XOR key byte.
module ark_byte_xor
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] i_state,
  input  logic [AES_BYTE_W-1:0] i_key,
  output logic [AES_BYTE_W-1:0] o_byte
);

  assign o_byte = i_state ^ i_key;

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey stage with valid/ready output register.
// Optional feature macro: ADD_ROUND_KEY_INREG_EN adds a chained input register stage.
module add_round_key
  import aes_pkg::*;
#(
  parameter int unsigned NB     = 4,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*NB*BYTE_W-1:0]   state_in,
  input  logic [4*NB*BYTE_W-1:0]   round_key,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*NB*BYTE_W-1:0]   state_out
);

  logic                   w_x_valid;
  logic [AES_STATE_W-1:0] w_x_state;
  logic [AES_STATE_W-1:0] w_x_key;
  logic                   w_out_ready;
  state_t                 w_state;
  state_t                 w_key;
  state_t                 w_res;

  logic                   r_out_valid;
  logic [AES_STATE_W-1:0] r_state_out;

  assign w_out_ready = !r_out_valid || out_ready;

`ifdef ADD_ROUND_KEY_INREG_EN
  ark_stage_t r_in;

  // Input stage frees up whenever the output stage will take its contents.
  assign in_ready = !r_in.valid || w_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in <= '0;
    end else if (in_ready) begin
      r_in.valid <= in_valid;
      if (in_valid) begin
        r_in.state <= state_in;
        r_in.key   <= round_key;
      end
    end
  end

  assign w_x_valid = r_in.valid;
  assign w_x_state = r_in.state;
  assign w_x_key   = r_in.key;
`else
  assign in_ready  = w_out_ready;
  assign w_x_valid = in_valid;
  assign w_x_state = state_in;
  assign w_x_key   = round_key;
`endif

  assign w_state = unpack_state(w_x_state);
  assign w_key   = unpack_state(w_x_key);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      ark_byte_xor u_lane (
        .i_state (w_state[r][c]),
        .i_key   (w_key[r][c]),
        .o_byte  (w_res[r][c])
      );
    end
  end

  // Data only moves on accept; a bare consume just drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_state_out <= '0;
    end else if (w_out_ready) begin
      r_out_valid <= w_x_valid;
      if (w_x_valid) begin
        r_state_out <= pack_state(w_res);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign state_out = r_state_out;

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: directed vector table, stall/reset
// sequences, and randomized streaming against a queue-based XOR model.
`timescale 1ns/1ps
module tb_add_round_key;

`ifdef ADD_ROUND_KEY_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int total = 0;
  int bad   = 0;

  add_round_key #(.NB(4), .BYTE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t         tv[4];
  logic [127:0] q[$];
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: every accepted input must later appear, in order, as a consumed output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want none", state_out);
        end else begin
          chk("stream_data", state_out, q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(state_in ^ round_key);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      step();
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 128'(q.size()), 128'd0);
  endtask

  logic [127:0] held;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    round_key = '0;

    tv[0] = '{"t1_28x74",   {16{8'd28}},  {16{8'd74}},  {16{8'h56}}};
    tv[1] = '{"t2_6x127",   {16{8'd6}},   {16{8'd127}}, {16{8'h79}}};
    tv[2] = '{"t2_195x13",  {16{8'd195}}, {16{8'd13}},  {16{8'hCE}}};
    tv[3].name = "t3_map";
    tv[3].key  = {16{8'hFF}};
    for (int i = 0; i < 16; i++) begin
      // byte index i = 4c+r in the column-major layout
      tv[3].st[8*i +: 8]  = 8'(i);
      tv[3].exp[8*i +: 8] = ~8'(i);
    end

    #12;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    chk("rst_in_ready",  128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: one accept each, check latency, result, then hold after consume
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      state_in  = tv[i].st;
      round_key = tv[i].key;
      step();
      in_valid = 1'b0;
      state_in = rand128();
      for (int k = 1; k < LAT; k++) begin
        chk({tv[i].name, "_early_valid"}, 128'(out_valid), 128'd0);
        step();
      end
      chk({tv[i].name, "_valid"}, 128'(out_valid), 128'd1);
      chk({tv[i].name, "_data"}, state_out, tv[i].exp);
      step();
      chk({tv[i].name, "_consumed"}, 128'(out_valid), 128'd0);
      chk({tv[i].name, "_hold"}, state_out, tv[i].exp);
    end

    // Backpressure: fill the pipe, then confirm nothing moves while stalled
    mon_en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid  = 1'b1;
      state_in  = rand128();
      round_key = rand128();
    end
    step();
    chk("stall_in_ready", 128'(in_ready), 128'd0);
    held = state_out;
    for (int i = 0; i < 3; i++) begin
      state_in  = rand128();
      round_key = rand128();
      step();
      chk("stall_in_ready", 128'(in_ready), 128'd0);
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_hold", state_out, held);
    end

    // Release with continuous traffic: one result per cycle, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      state_in  = rand128();
      round_key = rand128();
      chk("stream_in_ready", 128'(in_ready), 128'd1);
      chk("stream_valid", 128'(out_valid), 128'd1);
    end
    drain();

    // Randomized handshake traffic
    for (int i = 0; i < 300; i++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      state_in  = rand128();
      round_key = rand128();
    end
    drain();

    // Asynchronous reset while a result is pending
    mon_en = 1'b0;
    q.delete();
    out_ready = 1'b0;
    step();
    in_valid  = 1'b1;
    state_in  = tv[0].st;
    round_key = tv[0].key;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < LAT; k++) step();
    chk("pre_rst_valid", 128'(out_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(out_valid), 128'd0);
    chk("async_rst_data", state_out, 128'd0);
    chk("async_rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      chk("post_rst_idle", 128'(out_valid), 128'd0);
    end

    step();
    in_valid  = 1'b1;
    state_in  = tv[2].st;
    round_key = tv[2].key;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < LAT; k++) step();
    chk("post_rst_valid", 128'(out_valid), 128'd1);
    chk("post_rst_data", state_out, tv[2].exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
